execute_stage_controller: RTL and testbench
===========================================

EXECUTE_STAGE_CONTROLLER -- requirements
Module: execute_stage_controller

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64, max cycles to wait for md_done before faulting.
REQ-002 SHALL have parameter CNT_W, default 32, width of retired-op counter.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 issue_valid  in  1  decoded op available from decode stage.
REQ-006 issue_ready  out  1  controller accepts op this cycle.
REQ-007 op_class  in  2  00 ALU, 01 branch/jump, 10 mul/div, 11 reserved (treated as ALU).
REQ-008 branch_taken  in  1  resolved branch outcome, sampled with issue.
REQ-009 branch_target  in  64  resolved target PC, sampled with issue.
REQ-010 alu_enable  out  1  one-cycle ALU operand-capture strobe.
REQ-011 md_start  out  1  one-cycle mul/div launch pulse.
REQ-012 md_done  in  1  mul/div unit finished.
REQ-013 md_kill  out  1  one-cycle abort pulse to mul/div unit.
REQ-014 result_valid  out  1  result held for writeback.
REQ-015 wb_ready  in  1  writeback accepts result.
REQ-016 redirect_valid  out  1  one-cycle fetch redirect pulse.
REQ-017 redirect_pc  out  64  redirect target, valid with redirect_valid.
REQ-018 flush  in  1  downstream/exception flush of execute stage.
REQ-019 md_error  out  1  sticky mul/div timeout flag.
REQ-020 retired_cnt  out  CNT_W  count of results accepted by writeback.

Function
REQ-021 SHALL implement states IDLE, MD_WAIT, RESULT; IDLE after reset.
REQ-022 issue_ready SHALL be 1 in IDLE, 1 in RESULT only when wb_ready=1, 0 in MD_WAIT, 0 when flush=1.
REQ-023 Issue handshake = issue_valid & issue_ready; all control outputs decode from op_class in that same cycle.
REQ-024 ALU/reserved issue: alu_enable=1 same cycle; next state RESULT.
REQ-025 Branch issue: alu_enable=1 same cycle; next state RESULT; if branch_taken, redirect_valid=1 for exactly the next cycle with redirect_pc = registered branch_target.
REQ-026 Not-taken branch: redirect_valid stays 0; redirect_pc holds last value.
REQ-027 Mul/div issue: md_start=1 same cycle; next state MD_WAIT; wait counter cleared to 0.
REQ-028 MD_WAIT: counter increments each cycle; md_done=1 -> RESULT next cycle.
REQ-029 MD_WAIT counter reaching MD_TIMEOUT-1 without md_done: md_kill=1 that cycle, md_error set (sticky until reset), next state RESULT.
REQ-030 md_done and timeout in same cycle: md_done wins, no md_kill, no md_error.
REQ-031 RESULT: result_valid=1 held until wb_ready=1; result_valid=0 in all other states.
REQ-032 RESULT with wb_ready=1 and new issue same cycle: handled per REQ-024..027 (back-to-back, no bubble); without issue -> IDLE.
REQ-033 retired_cnt SHALL increment by 1 on each result_valid & wb_ready & ~flush, wrapping modulo 2^CNT_W.
REQ-034 flush=1: next state IDLE, held result dropped, no retire count; in MD_WAIT md_kill=1 same cycle; pending redirect pulse suppressed.
REQ-035 flush overrides issue, md_done and wb_ready in the same cycle.
REQ-036 alu_enable, md_start, md_kill, redirect_valid SHALL never exceed one cycle per accepted op.

Reset
REQ-037 Reset SHALL force IDLE, counters 0, md_error=0, redirect_pc=0, all strobes and result_valid 0, overriding every input including mid-MD_WAIT (no md_kill emitted).
REQ-038 issue_ready SHALL be 0 during reset cycle, 1 the first cycle after.

Verification
REQ-039 ALU issue in IDLE, wb_ready=1 -> alu_enable cycle 0, result_valid cycle 1, retired_cnt 0->1, IDLE cycle 2.
REQ-040 Taken branch target 0x0000_0000_8000_0040 -> redirect_valid pulse cycle 1, redirect_pc=0x80000040; not-taken repeat -> no pulse.
REQ-041 Mul/div with md_done at wait cycle 5 -> md_start cycle 0, issue_ready 0 cycles 1-5, result_valid cycle 6; with MD_TIMEOUT=8 and no md_done -> md_kill at wait count 7, md_error=1, RESULT next.
REQ-042 wb_ready held 0 for 3 cycles in RESULT -> result_valid stable 3 cycles, issue_ready 0; then wb_ready=1 with new ALU issue -> back-to-back accept, retired_cnt +1.
REQ-043 flush during MD_WAIT and during RESULT -> md_kill pulse (MD_WAIT only), IDLE next, retired_cnt unchanged.
REQ-044 reset asserted mid-MD_WAIT -> all outputs 0 next cycle, md_error cleared, retired_cnt 0.

Source files
------------

// File: rtl/execute_stage_controller.sv
// Execute-stage sequencer: accepts decoded ops, strobes ALU or mul/div, holds results for writeback, redirects fetch.
// Latency: ALU/branch result one cycle after issue; mul/div result one cycle after md_done (or timeout kill).
// Backpressure: result held while wb_ready=0 with issue_ready low; wb_ready=1 lets a new op issue in the same cycle.
module execute_stage_controller #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [1:0]       op_class,
  input  logic             branch_taken,
  input  logic [63:0]      branch_target,
  output logic             alu_enable,
  output logic             md_start,
  input  logic             md_done,
  output logic             md_kill,
  output logic             result_valid,
  input  logic             wb_ready,
  output logic             redirect_valid,
  output logic [63:0]      redirect_pc,
  input  logic             flush,
  output logic             md_error,
  output logic [CNT_W-1:0] retired_cnt
);

  // Wait counter only has to reach MD_TIMEOUT-1; the FSM leaves MD_WAIT there.
  localparam int WAIT_W = (MD_TIMEOUT < 2) ? 1 : $clog2(MD_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_MULDIV = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_WAIT = 2'd1,
    RESULT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              redirect_pend;
  logic [63:0]       redirect_pc_q;
  logic              md_error_q;
  logic [CNT_W-1:0]  retired_q;

  logic              op_is_md;
  logic              op_is_br;
  logic              issue_fire;
  logic              md_timeout;
  logic              retire;

  assign op_is_md = (op_class == OP_MULDIV);
  assign op_is_br = (op_class == OP_BRANCH);

  // A new op can enter when the stage is empty or its held result leaves this cycle.
  assign issue_ready = ~reset & ~flush &
                       ((state == IDLE) | ((state == RESULT) & wb_ready));
  assign issue_fire  = issue_valid & issue_ready;

  // md_done arriving on the last wait cycle beats the timeout.
  assign md_timeout = (state == MD_WAIT) & (wait_cnt == WAIT_LAST) & ~md_done;

  // A result only counts as retired if no flush discards it in the same cycle.
  assign retire = result_valid & wb_ready & ~flush;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush dominates every other input.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (issue_fire) begin
            state_nxt = op_is_md ? MD_WAIT : RESULT;
          end
        end
        MD_WAIT: begin
          if (md_done || (wait_cnt == WAIT_LAST)) begin
            state_nxt = RESULT;
          end
        end
        RESULT: begin
          if (wb_ready) begin
            if (issue_fire) begin
              state_nxt = op_is_md ? MD_WAIT : RESULT;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: strobes are tied to the issue handshake or the current state.
  always_comb begin
    alu_enable     = issue_fire & ~op_is_md;
    md_start       = issue_fire & op_is_md;
    md_kill        = ~reset & (state == MD_WAIT) & (flush | md_timeout);
    result_valid   = ~reset & (state == RESULT);
    redirect_valid = ~reset & ~flush & redirect_pend;
    redirect_pc    = redirect_pc_q;
    md_error       = md_error_q;
    retired_cnt    = retired_q;
  end

  // Mul/div wait counter: cleared on launch, counts while waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (md_start) begin
      wait_cnt <= '0;
    end else if (state == MD_WAIT) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Taken-branch redirect: pulse the cycle after issue, target held until the next taken branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_pend <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_pend <= issue_fire & op_is_br & branch_taken;
      if (issue_fire && op_is_br && branch_taken) begin
        redirect_pc_q <= branch_target;
      end
    end
  end

  // Sticky timeout flag; a flush-initiated kill is not an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_error_q <= 1'b0;
    end else if (md_timeout && !flush) begin
      md_error_q <= 1'b1;
    end
  end

  // Retired-op counter, wrapping naturally at its width.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_execute_stage_controller.sv
// Directed bench for execute_stage_controller with MD_TIMEOUT=8 and a 4-bit retire counter.
// Inputs change just after the falling edge; outputs are sampled 1 ns later, before the next rising edge.
// Each scenario task carries its own hand-computed expectations.
module tb_execute_stage_controller;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  op_class;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        alu_enable;
  logic        md_start;
  logic        md_done;
  logic        md_kill;
  logic        result_valid;
  logic        wb_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush;
  logic        md_error;
  logic [3:0]  retired_cnt;

  int vec;
  int miss;

  execute_stage_controller #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .op_class       (op_class),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .alu_enable     (alu_enable),
    .md_start       (md_start),
    .md_done        (md_done),
    .md_kill        (md_kill),
    .result_valid   (result_valid),
    .wb_ready       (wb_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .md_error       (md_error),
    .retired_cnt    (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; issue_valid = 1'b1; op_class = 2'b00; wb_ready = 1'b1;
    tick(); tick();
    #1;
    vec++; if (issue_ready !== 1'b0) begin miss++; $display("FAIL rst_issue_ready: got %b want 0", issue_ready); end
    vec++; if (alu_enable !== 1'b0) begin miss++; $display("FAIL rst_alu_enable: got %b want 0", alu_enable); end
    vec++; if (result_valid !== 1'b0) begin miss++; $display("FAIL rst_result_valid: got %b want 0", result_valid); end
    vec++; if (retired_cnt !== 4'd0) begin miss++; $display("FAIL rst_retired: got %0d want 0", retired_cnt); end
    vec++; if (md_error !== 1'b0) begin miss++; $display("FAIL rst_md_error: got %b want 0", md_error); end
    vec++; if (redirect_pc !== 64'h0) begin miss++; $display("FAIL rst_redirect_pc: got %0h want 0", redirect_pc); end
    issue_valid = 1'b0;
    reset = 1'b0;
    #1;
    vec++; if (issue_ready !== 1'b1) begin miss++; $display("FAIL post_rst_issue_ready: got %b want 1", issue_ready); end
    tick();
  endtask

  task automatic test_alu();
    issue_valid = 1'b1; op_class = 2'b00; wb_ready = 1'b1;
    #1;
    vec++; if (alu_enable !== 1'b1) begin miss++; $display("FAIL alu_c0_alu_enable: got %b want 1", alu_enable); end
    vec++; if (md_start !== 1'b0) begin miss++; $display("FAIL alu_c0_md_start: got %b want 0", md_start); end
    tick();
    issue_valid = 1'b0;
    #1;
    vec++; if (result_valid !== 1'b1) begin miss++; $display("FAIL alu_c1_result_valid: got %b want 1", result_valid); end
    vec++; if (alu_enable !== 1'b0) begin miss++; $display("FAIL alu_c1_alu_enable: got %b want 0", alu_enable); end
    vec++; if (retired_cnt !== 4'd0) begin miss++; $display("FAIL alu_c1_retired: got %0d want 0", retired_cnt); end
    tick();
    #1;
    vec++; if (result_valid !== 1'b0) begin miss++; $display("FAIL alu_c2_result_valid: got %b want 0", result_valid); end
    vec++; if (retired_cnt !== 4'd1) begin miss++; $display("FAIL alu_c2_retired: got %0d want 1", retired_cnt); end
    vec++; if (issue_ready !== 1'b1) begin miss++; $display("FAIL alu_c2_issue_ready: got %b want 1", issue_ready); end
  endtask

  task automatic test_branch();
    issue_valid = 1'b1; op_class = 2'b01; branch_taken = 1'b1; branch_target = 64'h0000_0000_8000_0040;
    #1;
    vec++; if (alu_enable !== 1'b1) begin miss++; $display("FAIL br_c0_alu_enable: got %b want 1", alu_enable); end
    vec++; if (redirect_valid !== 1'b0) begin miss++; $display("FAIL br_c0_redirect_valid: got %b want 0", redirect_valid); end
    tick();
    issue_valid = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    #1;
    vec++; if (redirect_valid !== 1'b1) begin miss++; $display("FAIL br_c1_redirect_valid: got %b want 1", redirect_valid); end
    vec++; if (redirect_pc !== 64'h0000_0000_8000_0040) begin miss++; $display("FAIL br_c1_redirect_pc: got %0h want 80000040", redirect_pc); end
    tick();
    // not-taken repeat
    issue_valid = 1'b1; op_class = 2'b01; branch_taken = 1'b0; branch_target = 64'h1234;
    #1;
    vec++; if (redirect_valid !== 1'b0) begin miss++; $display("FAIL br_c2_redirect_valid: got %b want 0", redirect_valid); end
    tick();
    issue_valid = 1'b0;
    #1;
    vec++; if (redirect_valid !== 1'b0) begin miss++; $display("FAIL brnt_c1_redirect_valid: got %b want 0", redirect_valid); end
    vec++; if (redirect_pc !== 64'h0000_0000_8000_0040) begin miss++; $display("FAIL brnt_c1_redirect_pc: got %0h want 80000040", redirect_pc); end
    vec++; if (result_valid !== 1'b1) begin miss++; $display("FAIL brnt_c1_result_valid: got %b want 1", result_valid); end
    tick();
    #1;
    vec++; if (retired_cnt !== 4'd3) begin miss++; $display("FAIL br_retired: got %0d want 3", retired_cnt); end
  endtask

  task automatic test_muldiv();
    // md_done on wait cycle 5
    issue_valid = 1'b1; op_class = 2'b10;
    #1;
    vec++; if (md_start !== 1'b1) begin miss++; $display("FAIL md_c0_md_start: got %b want 1", md_start); end
    vec++; if (alu_enable !== 1'b0) begin miss++; $display("FAIL md_c0_alu_enable: got %b want 0", alu_enable); end
    tick();
    for (int c = 1; c <= 5; c++) begin
      issue_valid = 1'b1; op_class = 2'b00; md_done = (c == 5);
      #1;
      vec++; if (issue_ready !== 1'b0) begin miss++; $display("FAIL md_c%0d_issue_ready: got %b want 0", c, issue_ready); end
      vec++; if (alu_enable !== 1'b0) begin miss++; $display("FAIL md_c%0d_alu_enable: got %b want 0", c, alu_enable); end
      vec++; if (result_valid !== 1'b0) begin miss++; $display("FAIL md_c%0d_result_valid: got %b want 0", c, result_valid); end
      vec++; if (md_kill !== 1'b0) begin miss++; $display("FAIL md_c%0d_md_kill: got %b want 0", c, md_kill); end
      tick();
    end
    issue_valid = 1'b0; md_done = 1'b0;
    #1;
    vec++; if (result_valid !== 1'b1) begin miss++; $display("FAIL md_c6_result_valid: got %b want 1", result_valid); end
    tick();

    // md_done on the timeout cycle: done wins
    issue_valid = 1'b1; op_class = 2'b10;
    tick();
    issue_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      md_done = (c == 8);
      #1;
      vec++; if (md_kill !== 1'b0) begin miss++; $display("FAIL tie_c%0d_md_kill: got %b want 0", c, md_kill); end
      tick();
    end
    md_done = 1'b0;
    #1;
    vec++; if (result_valid !== 1'b1) begin miss++; $display("FAIL tie_c9_result_valid: got %b want 1", result_valid); end
    vec++; if (md_error !== 1'b0) begin miss++; $display("FAIL tie_c9_md_error: got %b want 0", md_error); end
    tick();

    // no md_done: kill at wait count 7 (cycle 8)
    issue_valid = 1'b1; op_class = 2'b10;
    tick();
    issue_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      vec++; if (md_kill !== (c == 8)) begin miss++; $display("FAIL to_c%0d_md_kill: got %b want %b", c, md_kill, (c == 8)); end
      tick();
    end
    #1;
    vec++; if (result_valid !== 1'b1) begin miss++; $display("FAIL to_c9_result_valid: got %b want 1", result_valid); end
    vec++; if (md_error !== 1'b1) begin miss++; $display("FAIL to_c9_md_error: got %b want 1", md_error); end
    vec++; if (md_kill !== 1'b0) begin miss++; $display("FAIL to_c9_md_kill: got %b want 0", md_kill); end
    tick();
    #1;
    vec++; if (retired_cnt !== 4'd6) begin miss++; $display("FAIL md_retired: got %0d want 6", retired_cnt); end
    vec++; if (md_error !== 1'b1) begin miss++; $display("FAIL md_error_sticky: got %b want 1", md_error); end
  endtask

  task automatic test_backpressure();
    issue_valid = 1'b1; op_class = 2'b00; wb_ready = 1'b0;
    tick();
    issue_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      vec++; if (result_valid !== 1'b1) begin miss++; $display("FAIL bp_c%0d_result_valid: got %b want 1", c, result_valid); end
      vec++; if (issue_ready !== 1'b0) begin miss++; $display("FAIL bp_c%0d_issue_ready: got %b want 0", c, issue_ready); end
      vec++; if (retired_cnt !== 4'd6) begin miss++; $display("FAIL bp_c%0d_retired: got %0d want 6", c, retired_cnt); end
      tick();
    end
    wb_ready = 1'b1; issue_valid = 1'b1; op_class = 2'b11;
    #1;
    vec++; if (issue_ready !== 1'b1) begin miss++; $display("FAIL bp_c4_issue_ready: got %b want 1", issue_ready); end
    vec++; if (alu_enable !== 1'b1) begin miss++; $display("FAIL bp_c4_alu_enable: got %b want 1", alu_enable); end
    tick();
    issue_valid = 1'b0;
    #1;
    vec++; if (result_valid !== 1'b1) begin miss++; $display("FAIL bp_c5_result_valid: got %b want 1", result_valid); end
    vec++; if (retired_cnt !== 4'd7) begin miss++; $display("FAIL bp_c5_retired: got %0d want 7", retired_cnt); end
    tick();
    #1;
    vec++; if (retired_cnt !== 4'd8) begin miss++; $display("FAIL bp_c6_retired: got %0d want 8", retired_cnt); end
  endtask

  task automatic test_flush();
    // flush in MD_WAIT, with md_done also high
    issue_valid = 1'b1; op_class = 2'b10;
    tick();
    issue_valid = 1'b0;
    tick();
    flush = 1'b1; md_done = 1'b1;
    #1;
    vec++; if (md_kill !== 1'b1) begin miss++; $display("FAIL fl_md_md_kill: got %b want 1", md_kill); end
    vec++; if (issue_ready !== 1'b0) begin miss++; $display("FAIL fl_md_issue_ready: got %b want 0", issue_ready); end
    tick();
    flush = 1'b0; md_done = 1'b0;
    #1;
    vec++; if (result_valid !== 1'b0) begin miss++; $display("FAIL fl_md_next_result_valid: got %b want 0", result_valid); end
    vec++; if (issue_ready !== 1'b1) begin miss++; $display("FAIL fl_md_next_issue_ready: got %b want 1", issue_ready); end
    vec++; if (md_kill !== 1'b0) begin miss++; $display("FAIL fl_md_next_md_kill: got %b want 0", md_kill); end
    // flush in RESULT, overriding wb_ready and a new issue
    issue_valid = 1'b1; op_class = 2'b00;
    tick();
    flush = 1'b1; wb_ready = 1'b1; issue_valid = 1'b1;
    #1;
    vec++; if (md_kill !== 1'b0) begin miss++; $display("FAIL fl_res_md_kill: got %b want 0", md_kill); end
    vec++; if (alu_enable !== 1'b0) begin miss++; $display("FAIL fl_res_alu_enable: got %b want 0", alu_enable); end
    tick();
    flush = 1'b0; issue_valid = 1'b0;
    #1;
    vec++; if (result_valid !== 1'b0) begin miss++; $display("FAIL fl_res_next_result_valid: got %b want 0", result_valid); end
    vec++; if (retired_cnt !== 4'd8) begin miss++; $display("FAIL fl_res_retired: got %0d want 8", retired_cnt); end
    // flush suppresses a pending redirect pulse
    issue_valid = 1'b1; op_class = 2'b01; branch_taken = 1'b1; branch_target = 64'hABC0;
    tick();
    issue_valid = 1'b0; branch_taken = 1'b0; flush = 1'b1;
    #1;
    vec++; if (redirect_valid !== 1'b0) begin miss++; $display("FAIL fl_redirect_valid: got %b want 0", redirect_valid); end
    tick();
    flush = 1'b0;
    #1;
    vec++; if (redirect_valid !== 1'b0) begin miss++; $display("FAIL fl_redirect_after: got %b want 0", redirect_valid); end
    vec++; if (retired_cnt !== 4'd8) begin miss++; $display("FAIL fl_br_retired: got %0d want 8", retired_cnt); end
  endtask

  task automatic test_back_to_back();
    // eight ALU ops with no bubble take the 4-bit counter from 8 through 15 to 0
    wb_ready = 1'b1; op_class = 2'b00;
    for (int c = 0; c < 8; c++) begin
      issue_valid = 1'b1;
      #1;
      vec++; if (alu_enable !== 1'b1) begin miss++; $display("FAIL b2b_c%0d_alu_enable: got %b want 1", c, alu_enable); end
      tick();
    end
    issue_valid = 1'b0;
    #1;
    vec++; if (retired_cnt !== 4'd15) begin miss++; $display("FAIL b2b_retired15: got %0d want 15", retired_cnt); end
    vec++; if (result_valid !== 1'b1) begin miss++; $display("FAIL b2b_last_result_valid: got %b want 1", result_valid); end
    tick();
    #1;
    vec++; if (retired_cnt !== 4'd0) begin miss++; $display("FAIL b2b_wrap: got %0d want 0", retired_cnt); end
  endtask

  task automatic test_reset_mid_md();
    issue_valid = 1'b1; op_class = 2'b01; branch_taken = 1'b1; branch_target = 64'h55AA;
    tick();
    issue_valid = 1'b1; op_class = 2'b10; branch_taken = 1'b0;
    tick();
    issue_valid = 1'b0;
    tick(); tick();
    reset = 1'b1; md_done = 1'b1; flush = 1'b1;
    #1;
    vec++; if (md_kill !== 1'b0) begin miss++; $display("FAIL rmd_md_kill: got %b want 0", md_kill); end
    vec++; if (issue_ready !== 1'b0) begin miss++; $display("FAIL rmd_issue_ready: got %b want 0", issue_ready); end
    tick();
    reset = 1'b0; md_done = 1'b0; flush = 1'b0;
    #1;
    vec++; if (result_valid !== 1'b0) begin miss++; $display("FAIL rmd_result_valid: got %b want 0", result_valid); end
    vec++; if (md_kill !== 1'b0) begin miss++; $display("FAIL rmd_next_md_kill: got %b want 0", md_kill); end
    vec++; if (md_error !== 1'b0) begin miss++; $display("FAIL rmd_md_error: got %b want 0", md_error); end
    vec++; if (retired_cnt !== 4'd0) begin miss++; $display("FAIL rmd_retired: got %0d want 0", retired_cnt); end
    vec++; if (redirect_pc !== 64'h0) begin miss++; $display("FAIL rmd_redirect_pc: got %0h want 0", redirect_pc); end
    vec++; if (redirect_valid !== 1'b0) begin miss++; $display("FAIL rmd_redirect_valid: got %b want 0", redirect_valid); end
    vec++; if (issue_ready !== 1'b1) begin miss++; $display("FAIL rmd_issue_ready_after: got %b want 1", issue_ready); end
    tick();
  endtask

  initial begin
    vec = 0; miss = 0;
    reset = 1'b1; issue_valid = 1'b0; op_class = 2'b00; branch_taken = 1'b0;
    branch_target = 64'h0; md_done = 1'b0; wb_ready = 1'b1; flush = 1'b0;
    tick();
    test_reset();
    test_alu();
    test_branch();
    test_muldiv();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid_md();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
